// File: rtl/hcu_round_sequencer.sv
// rtl/hcu_round_sequencer.sv - round sequencing FSM for the HCU compression datapath
//
// Purpose: accepts a block-start request, then drives one compression of the
// working registers a..h: one init_load cycle, 64 (SHA-256) or 80 (SHA-512)
// rounds paced by message-scheduler word availability, one final_add cycle,
// and a done handshake. Owns round_idx, the K constant ROM address.
//
// Optional feature macro: HCU_STALL_CNT_EN (round-phase stall counter).
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous, active-high reset
//   start_valid  in   request to compress one block
//   start_ready  out  sequencer idle, can accept a start
//   mode_512     in   sampled with start: 1 = 80 rounds, 0 = 64 rounds
//   w_valid      in   scheduler presents W[round_idx]
//   w_ready      out  W word consumed this cycle
//   init_load    out  load a..h from hash state
//   round_en     out  datapath executes one round
//   round_idx    out  current round number
//   final_add    out  add a..h into hash state
//   done_valid   out  digest update complete
//   done_ready   in   consumer acknowledges completion
//   busy         out  not idle
//   stall_cnt    out  round-phase stall cycles (zero when feature disabled)

module hcu_round_sequencer #(
  parameter int ROUNDS_256 = 64,
  parameter int ROUNDS_512 = 80,
  parameter int IDX_W      = 7,
  parameter int STALL_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic               mode_512,
  input  logic               w_valid,
  output logic               w_ready,
  output logic               init_load,
  output logic               round_en,
  output logic [IDX_W-1:0]   round_idx,
  output logic               final_add,
  output logic               done_valid,
  input  logic               done_ready,
  output logic               busy,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_256 = IDX_W'(ROUNDS_256 - 1);
  localparam logic [IDX_W-1:0] LAST_512 = IDX_W'(ROUNDS_512 - 1);

  state_t           state;
  state_t           state_nxt;
  logic             mode_q;
  logic [IDX_W-1:0] idx_q;
  logic             last_idx;

  assign last_idx  = (idx_q == (mode_q ? LAST_512 : LAST_256));
  assign round_idx = idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      mode_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            mode_q <= mode_512;
          end
        end
        S_INIT: begin
          idx_q <= '0;
        end
        S_ROUND: begin
          // The last round leaves the index at LAST so it never wraps.
          if (w_valid && !last_idx) begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (done_ready) begin
            idx_q <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    init_load   = 1'b0;
    round_en    = 1'b0;
    w_ready     = 1'b0;
    final_add   = 1'b0;
    done_valid  = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        init_load = 1'b1;
        state_nxt = S_ROUND;
      end
      S_ROUND: begin
        // Round strobe and word consumption are the same event.
        round_en = w_valid;
        w_ready  = w_valid;
        if (w_valid && last_idx) begin
          state_nxt = S_FINAL;
        end
      end
      S_FINAL: begin
        final_add = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done_valid = 1'b1;
        if (done_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef HCU_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q;

  // Cleared at the start of every job; holds through FINAL/DONE/IDLE so
  // software can read the last job's stall total.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state == S_INIT) begin
      stall_q <= '0;
    end else if ((state == S_ROUND) && !w_valid && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hcu_round_sequencer.sv
// tb/tb_hcu_round_sequencer.sv - scoreboard bench for hcu_round_sequencer
//
// Stimulus tasks compute, per job, the cycle-by-cycle event timeline from the
// round count and the stall pattern they will drive, and queue it. A monitor
// on the falling edge pops and compares whenever the DUT shows a strobe.

module tb_hcu_round_sequencer;

  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic        mode_512;
  logic        w_valid;
  logic        w_ready;
  logic        init_load;
  logic        round_en;
  logic [6:0]  round_idx;
  logic        final_add;
  logic        done_valid;
  logic        done_ready;
  logic        busy;
  logic [15:0] stall_cnt;

  hcu_round_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .mode_512    (mode_512),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .init_load   (init_load),
    .round_en    (round_en),
    .round_idx   (round_idx),
    .final_add   (final_add),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy),
    .stall_cnt   (stall_cnt)
  );

  // kind: 0 init_load, 1 round_en, 2 final_add, 3 done_valid
  typedef struct {
    int kind;
    int idx;
    int cyc;
    int stall;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   exp_idle = 0;
  bit   mon_en   = 0;
  int   st[80];
  int   m_kind;
  exp_t m_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_side();
    mode_512   = 1'($urandom % 2);
    done_ready = 1'($urandom % 2);
  endtask

  // Monitor: scoreboard pop/compare on every DUT strobe.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("strobe_exclusive", longint'($countones({init_load, round_en, final_add}) <= 1), 1);
      chk("w_ready_eq_round_en", w_ready, round_en);
      chk("start_ready_eq_not_busy", start_ready, !busy);
      if (init_load || round_en || final_add || done_valid) begin
        m_kind = init_load ? 0 : round_en ? 1 : final_add ? 2 : 3;
        if (sbq.size() == 0) begin
          chk("unexpected_event_kind", m_kind, -1);
        end else begin
          m_e = sbq.pop_front();
          chk("event_kind", m_kind, m_e.kind);
          chk("event_cycle", cyc, m_e.cyc);
          if (m_kind == 1) chk("round_idx", round_idx, m_e.idx);
          if (m_kind == 3) begin
            chk("stall_cnt_at_done", stall_cnt, m_e.stall);
            chk("start_ready_in_done", start_ready, 0);
          end
        end
      end else begin
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
          chk("missed_event_kind", sbq[0].kind, -1);
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic run_job(input bit m, input int delay, input bit sv_done, input int abort_at);
    int n, t0, s, tc, es;
    bit ok;
    n           = m ? 80 : 64;
    mode_512    = m;
    start_valid = 1'b1;
    ok          = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (start_ready) begin
        ok = 1'b1;
        break;
      end
      next_cycle();
    end
    if (!ok) begin
      chk("start_accept_timeout", 0, 1);
      start_valid = 1'b0;
      return;
    end
    t0 = cyc;
    chk("start_accept_cycle", t0, exp_idle);

    // Expected timeline: INIT at t0+1, rounds from t0+2, each preceded by its stalls.
    sbq.push_back('{0, 0, t0 + 1, 0});
    tc = t0 + 2;
    s  = 0;
    for (int r = 0; r < n; r++) begin
      tc += st[r];
      s  += st[r];
      if (abort_at < 0 || r < abort_at) sbq.push_back('{1, r, tc, 0});
      tc++;
    end
`ifdef HCU_STALL_CNT_EN
    es = (s > 65535) ? 65535 : s;
`else
    es = 0;
`endif
    if (abort_at < 0) begin
      sbq.push_back('{2, 0, tc, 0});
      for (int d = 0; d <= delay; d++) sbq.push_back('{3, 0, tc + 1 + d, es});
    end

    next_cycle();
    start_valid = 1'b0;
    rnd_side();
    w_valid = 1'($urandom % 2);
    for (int r = 0; r < n; r++) begin
      for (int k = 0; k < st[r]; k++) begin
        next_cycle();
        rnd_side();
        w_valid = 1'b0;
      end
      next_cycle();
      rnd_side();
      w_valid = 1'b1;
      if (r == abort_at) begin
        rst = 1'b1;
        next_cycle();
        rst     = 1'b0;
        w_valid = 1'b0;
        done_ready = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_round_idx", round_idx, 0);
        chk("abort_start_ready", start_ready, 1);
        chk("abort_final_add", final_add, 0);
        chk("abort_stall_cnt", stall_cnt, 0);
        exp_idle = cyc;
        return;
      end
    end
    next_cycle();
    rnd_side();
    w_valid = 1'($urandom % 2);
    for (int d = 0; d <= delay; d++) begin
      next_cycle();
      mode_512    = 1'($urandom % 2);
      w_valid     = 1'($urandom % 2);
      done_ready  = (d == delay);
      start_valid = sv_done;
    end
    next_cycle();
    done_ready  = 1'b0;
    start_valid = 1'b0;
    exp_idle    = cyc;
  endtask

  task automatic clear_stalls();
    for (int r = 0; r < 80; r++) st[r] = 0;
  endtask

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    mode_512    = 1'b0;
    w_valid     = 1'b0;
    done_ready  = 1'b0;
    repeat (3) next_cycle();
    chk("reset_start_ready", start_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_round_idx", round_idx, 0);
    chk("reset_stall_cnt", stall_cnt, 0);
    chk("reset_strobes", {init_load, round_en, final_add, done_valid, w_ready}, 0);
    rst      = 1'b0;
    exp_idle = cyc;
    mon_en   = 1'b1;

    clear_stalls();
    run_job(1'b0, 1, 1'b0, -1);
    run_job(1'b1, 0, 1'b0, -1);
    st[10] = 3;
    st[40] = 3;
    run_job(1'b0, 0, 1'b0, -1);
    clear_stalls();
    run_job(1'b0, 0, 1'b0, 30);
    run_job(1'b0, 5, 1'b1, -1);
    for (int j = 0; j < 10; j++) begin
      for (int r = 0; r < 80; r++) st[r] = ($urandom % 6 == 0) ? $urandom_range(1, 3) : 0;
      run_job(1'($urandom % 2), $urandom_range(0, 4), 1'($urandom % 2), -1);
    end

    repeat (3) next_cycle();
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
